// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Self-synchronising receive checker for the 8-bit LFSR stream
//               (taps 7,6,3,2,1,0, shift-left). Locks, counts bit errors.
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_checker #(
  parameter int LOCK_MATCHES = 16,
  parameter int UNLOCK_ERRS  = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] error_count,
  output logic             stuck_zero
);

  localparam logic [7:0]       TAP_MASK   = 8'hCF;
  localparam logic [7:0]       LOCK_TGT   = 8'(LOCK_MATCHES);
  localparam logic [7:0]       UNLOCK_TGT = 8'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stuck_q, stuck_d;

  logic             pred;
  logic             mismatch;
  logic [7:0]       hist_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      count_q  <= count_d;
      stuck_q  <= stuck_d;
    end
  end

  always_comb begin
    // Prediction uses the history before the incoming bit is shifted in.
    pred       = ^(hist_q & TAP_MASK);
    mismatch   = bit_valid && (bit_in != pred);
    hist_shift = {hist_q[6:0], bit_in};

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    error_d = 1'b0;
    count_d = count_q;

    if (clear_count) begin
      count_d = '0;
    end

    if (bit_valid) begin
      hist_d = hist_shift;
      case (state_q)
        ST_FILL: begin
          if (fill_q == 3'd7) begin
            state_d = ST_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        ST_VERIFY: begin
          // An all-zero history predicts zeros forever, so it never counts toward lock.
          if (mismatch || (hist_shift == 8'd0)) begin
            match_d = '0;
          end else if (match_q + 8'd1 == LOCK_TGT) begin
            state_d = ST_LOCKED;
            match_d = match_q + 8'd1;
            miss_d  = '0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end

        ST_LOCKED: begin
          if (mismatch) begin
            error_d = 1'b1;
            if (count_d != CNT_MAX) begin
              count_d = count_d + CNT_ONE;
            end
            if (miss_q + 8'd1 == UNLOCK_TGT) begin
              state_d = ST_VERIFY;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = '0;
          end
          if (hist_shift == 8'd0) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end

        default: begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    stuck_d  = (hist_d == 8'd0) && (state_d != ST_FILL);
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign error_count = count_q;
  assign stuck_zero  = stuck_q;

endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's 8-bit LFSR sequence generator.
- Consumes the generator's 1-bit output stream and self-synchronises to it. It then checks every subsequent bit against the polynomial and counts bit errors.
- Used for loopback and link BIST: the generator drives the link and this block sits at the far end.

Parameters:
- LOCK_MATCHES, 16: consecutive correct predictions needed to declare lock (1..255).
- UNLOCK_ERRS, 8: consecutive mispredictions while locked that drop lock (1..255).
- CNT_W, 16: width of the error counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- bit_valid, input, 1: bit_in is sampled this cycle.
- bit_in, input, 1: received sequence bit.
- clear_count, input, 1: synchronous clear of error_count.
- locked, output, 1: checker is synchronised to the sequence.
- error, output, 1: one-cycle pulse marking a mispredicted bit while locked.
- error_count, output, CNT_W: saturating count of errors while locked.
- stuck_zero, output, 1: history register is all zeros (degenerate LFSR state).

Behaviour:
- Reset (asynchronous, rst=1): hist=0, FSM=FILL, fill/match/miss counters=0. locked=0, error=0, error_count=0, stuck_zero=0.
- History: on bit_valid=1, hist <= {hist[6:0], bit_in}. No update when bit_valid=0; all state holds.
- Prediction (combinational, from pre-shift hist): pred = hist[7]^hist[6]^hist[3]^hist[2]^hist[1]^hist[0].
  - mismatch = bit_valid & (bit_in != pred).
  - This matches the generator's shift-left feedback exactly.
- FSM, evaluated only on bit_valid=1 cycles:
  - FILL: count 8 accepted bits, no comparison. After the 8th bit, go to VERIFY with match_cnt=0.
  - VERIFY: a match increments match_cnt; a mismatch clears it.
    - If the post-shift hist==0, hold match_cnt at 0.
    - When match_cnt reaches LOCK_MATCHES, go to LOCKED with miss_cnt=0. locked rises on that same clock edge.
  - LOCKED: a mismatch raises error in the next cycle, increments error_count and increments miss_cnt. A match clears miss_cnt.
    - miss_cnt reaching UNLOCK_ERRS goes to VERIFY with match_cnt=0.
    - A post-shift hist==0 also goes to VERIFY.
    - locked falls on the transition edge. The mismatch that triggers unlock is still counted and pulsed.
- Outputs are registered.
  - locked = (state==LOCKED).
  - error is high for exactly one cycle per mismatched bit; it is 0 in FILL and VERIFY.
  - stuck_zero = (hist==0) && state!=FILL, updated with hist.
- Counter:
  - error_count saturates at 2^CNT_W-1; it never wraps.
  - clear_count=1 sets it to 0. If clear_count and a locked mismatch occur in the same cycle, the result is 1.
  - clear_count has no effect on the FSM.
- Error multiplication: one flipped bit while locked yields 7 mismatches.
  - One for the flipped bit itself, plus one at each later tap distance 1,2,3,4,7,8.
  - The longest consecutive run is 5, so a single flip does not drop lock at the default UNLOCK_ERRS.
- Reset mid-operation returns to FILL immediately and requires a full re-lock.

Test Plan:
- Reset, then feed the generator stream seeded 8'h01, one bit per cycle → locked rises after exactly 8+16=24 accepted bits. error stays 0 and error_count=0 for a further 1000 bits.
- Locked, flip one bit → exactly 7 error pulses at bit offsets 0,1,2,3,4,7,8 from the flipped bit. error_count=7 and locked stays 1.
- Locked, replace the stream with 8 consecutive inverted predicted bits → locked falls after the 8th. Feeding the clean sequence again re-locks after 16 matches.
- Feed an all-zero stream → stuck_zero=1 after the 8th bit and locked never asserts. Then feed the generator stream → stuck_zero clears and lock occurs.
- CNT_W=3, locked with a continuously inverted-tap stream → error_count saturates at 7. clear_count pulsed coincident with an error → count=1.
- bit_valid toggled in a random pattern with the same stream → lock timing counts only valid bits and all state holds on idle cycles. rst asserted mid-LOCKED → all outputs 0 asynchronously, FSM in FILL.
